// File: rtl/tqvp_jnms_pdm_multi.sv
// PDM microphone front end for TinyQV: PDM clock generation, left/right sampling on
// opposite clock edges, per-channel CIC decimation to PCM, frame FIFO and interrupt.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   ui_in             input PMOD, ui_in[DIN_BIT] carries the PDM data bit
//   uo_out            gated PDM clock on every bit
//   address, data_in  register address and write data
//   data_write_n      11 none, 00 byte, 01 half, 10 word
//   data_read_n       11 none, anything else is a read
//   data_out          read data, combinational from address
//   data_ready        always 1
//   user_interrupt    OVER or FIFO level at/above THRESH
module tqvp_jnms_pdm_multi #(
    parameter int unsigned ORDER      = 3,
    parameter int unsigned DECIM_LOG2 = 6,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIN_BIT    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int unsigned W  = ORDER * DECIM_LOG2 + 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_PERIOD = 6'h04;
    localparam logic [5:0] A_DATA   = 6'h08;
    localparam logic [5:0] A_STATUS = 6'h0C;

    // 2**(W-1) in W+2 bits: the CIC gain R**ORDER
    localparam logic [W+1:0] GAIN = {3'b001, {(W-1){1'b0}}};

    // The CIC runs on the raw bit b in {0,1}; the +/-1 result is 2*y - R**ORDER.
    // y lies in [0, R**ORDER] and is exact in W bits, so +full scale stays
    // distinguishable from -full scale and can be saturated.
    function automatic logic [OUT_W-1:0] cic_to_pcm(input logic [W-1:0] y);
        logic [W+1:0] r;
        logic [W-1:0] s;
        r = {1'b0, y, 1'b0} - GAIN;
        if (r == GAIN) s = {1'b0, {(W-1){1'b1}}};
        else           s = r[W-1:0];
        return s[W-1 -: OUT_W];
    endfunction

    function automatic logic [15:0] sext16(input logic [OUT_W-1:0] v);
        return 16'($signed(v));
    endfunction

    // Register state
    logic                  en_q, en_d;
    logic                  stereo_q, stereo_d;
    logic [3:0]            thresh_q, thresh_d;
    logic [7:0]            period_q, period_d;
    logic                  over_q, over_d;
    logic                  under_q, under_d;
    logic [7:0]            phase_q, phase_d;
    logic                  pdm_prev_q, pdm_prev_d;
    logic [DECIM_LOG2-1:0] dcnt_q, dcnt_d;
    logic                  pend_q, pend_d;
    logic [OUT_W-1:0]      left_pcm_q, left_pcm_d;
    logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [W-1:0]          integ_q [2][ORDER];
    logic [W-1:0]          integ_d [2][ORDER];
    logic [W-1:0]          comb_q  [2][ORDER];
    logic [W-1:0]          comb_d  [2][ORDER];
    logic [31:0]           mem_q   [FIFO_DEPTH];

    logic                  stereo_eff_c, din_c, pdm_clk_c, rise_c, fall_c;
    logic [7:0]            per_eff_c;
    logic [1:0]            samp_c, dump_c;
    logic [W-1:0]          cic_y_c [2];
    logic [OUT_W-1:0]      pcm_l_c, pcm_r_c;
    logic                  push_c, pop_c, rd_data_c, full_c, empty_c, flush_c;
    logic                  do_push_c, over_set_c, under_set_c, wr_c;
    logic [LW-1:0]         level_c;
    logic [31:0]           wmask_c, wdata_c, push_data_c;
    logic                  unused_sink;

    assign stereo_eff_c = (NUM_CH > 1) && stereo_q;
    assign din_c        = ui_in[DIN_BIT];
    assign per_eff_c    = (period_q < 8'd2) ? 8'd2 : period_q;
    assign pdm_clk_c    = phase_q < (per_eff_c >> 1);
    assign rise_c       = en_q && !pdm_prev_q && pdm_clk_c;
    assign fall_c       = en_q && pdm_prev_q && !pdm_clk_c;
    assign uo_out       = {8{en_q & pdm_clk_c}};
    assign data_ready   = 1'b1;
    assign unused_sink  = ^{ui_in, wdata_c};

    // Left on falling edge; right on rising edge, dumping on the first right
    // sample after the left channel's decimation point.
    assign samp_c[0] = fall_c;
    assign samp_c[1] = rise_c && stereo_eff_c;
    assign dump_c[0] = fall_c && (dcnt_q == '1);
    assign dump_c[1] = samp_c[1] && pend_q;

    // Clock generator and decimation bookkeeping
    always_comb begin : clkgen_next
        phase_d    = (phase_q >= per_eff_c - 8'd1) ? 8'd0 : phase_q + 8'd1;
        pdm_prev_d = pdm_clk_c;
        dcnt_d     = fall_c ? dcnt_q + DECIM_LOG2'(1) : dcnt_q;
        pend_d     = pend_q;
        if (dump_c[0] && stereo_eff_c) pend_d = 1'b1;
        else if (dump_c[1] || !stereo_eff_c) pend_d = 1'b0;
        left_pcm_d = dump_c[0] ? pcm_l_c : left_pcm_q;
        if (!en_q) begin
            phase_d    = '0;
            pdm_prev_d = 1'b0;
            dcnt_d     = '0;
            pend_d     = 1'b0;
            left_pcm_d = '0;
        end
    end

    // CIC integrator chain per sample, comb chain per decimation point
    always_comb begin : cic_next
        logic [W-1:0] acc;
        for (int ch = 0; ch < 2; ch++) begin
            cic_y_c[ch] = '0;
            for (int k = 0; k < ORDER; k++) begin
                integ_d[ch][k] = integ_q[ch][k];
                comb_d[ch][k]  = comb_q[ch][k];
            end
            acc = W'(din_c);
            if (samp_c[ch]) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ_d[ch][k] = integ_q[ch][k] + acc;
                    acc            = integ_d[ch][k];
                end
            end
            acc = integ_d[ch][ORDER-1];
            if (dump_c[ch]) begin
                for (int k = 0; k < ORDER; k++) begin
                    comb_d[ch][k] = acc;
                    acc           = acc - comb_q[ch][k];
                end
                cic_y_c[ch] = acc;
            end
            if (!en_q) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ_d[ch][k] = '0;
                    comb_d[ch][k]  = '0;
                end
            end
        end
    end

    assign pcm_l_c     = cic_to_pcm(cic_y_c[0]);
    assign pcm_r_c     = cic_to_pcm(cic_y_c[1]);
    assign push_c      = (dump_c[0] && !stereo_eff_c) || dump_c[1];
    assign push_data_c = {stereo_eff_c ? sext16(pcm_r_c) : 16'h0000,
                          sext16(stereo_eff_c ? left_pcm_q : pcm_l_c)};

    // FIFO occupancy and handshake
    assign level_c     = wr_ptr_q - rd_ptr_q;
    assign empty_c     = (level_c == '0);
    assign full_c      = (level_c == LW'(FIFO_DEPTH));
    assign rd_data_c   = (data_read_n != 2'b11) && (address == A_DATA);
    assign pop_c       = rd_data_c && !empty_c && !flush_c;
    assign under_set_c = rd_data_c && empty_c;
    assign do_push_c   = push_c && !flush_c && (!full_c || pop_c);
    assign over_set_c  = push_c && !flush_c && full_c && !pop_c;

    // Bus writes, flags and FIFO pointers
    always_comb begin : regs_next
        wr_c = (data_write_n != 2'b11);
        case (data_write_n)
            2'b00:   wmask_c = 32'h0000_00FF;
            2'b01:   wmask_c = 32'h0000_FFFF;
            default: wmask_c = 32'hFFFF_FFFF;
        endcase
        wdata_c  = data_in & wmask_c;
        en_d     = en_q;
        stereo_d = stereo_q;
        thresh_d = thresh_q;
        period_d = period_q;
        over_d   = over_q;
        under_d  = under_q;
        flush_c  = 1'b0;
        if (wr_c) begin
            case (address)
                A_CTRL: begin
                    en_d     = wdata_c[0];
                    stereo_d = wdata_c[1];
                    flush_c  = wdata_c[2];
                    if (wmask_c[8]) thresh_d = wdata_c[11:8];
                end
                A_PERIOD: period_d = wdata_c[7:0];
                A_STATUS: begin
                    if (wdata_c[10]) over_d  = 1'b0;
                    if (wdata_c[11]) under_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (over_set_c)  over_d  = 1'b1;
        if (under_set_c) under_d = 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push_c) wr_ptr_d = wr_ptr_q + LW'(1);
            if (pop_c)     rd_ptr_d = rd_ptr_q + LW'(1);
        end
    end

    // Read mux
    always_comb begin : read_mux
        data_out = '0;
        case (address)
            A_CTRL:   data_out = {20'h0, thresh_q, 6'h0, stereo_eff_c, en_q};
            A_PERIOD: data_out = {24'h0, period_q};
            A_DATA:   data_out = empty_c ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
            A_STATUS: data_out = {20'h0, under_q, over_q, full_c, empty_c, 3'b000, 5'(level_c)};
            default:  data_out = '0;
        endcase
    end

    assign user_interrupt = over_q || ((thresh_q != 4'h0) && (32'(level_c) >= 32'(thresh_q)));

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            stereo_q   <= 1'b0;
            thresh_q   <= '0;
            period_q   <= '0;
            over_q     <= 1'b0;
            under_q    <= 1'b0;
            phase_q    <= '0;
            pdm_prev_q <= 1'b0;
            dcnt_q     <= '0;
            pend_q     <= 1'b0;
            left_pcm_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ_q[ch][k] <= '0;
                    comb_q[ch][k]  <= '0;
                end
            end
        end else begin
            en_q       <= en_d;
            stereo_q   <= stereo_d;
            thresh_q   <= thresh_d;
            period_q   <= period_d;
            over_q     <= over_d;
            under_q    <= under_d;
            phase_q    <= phase_d;
            pdm_prev_q <= pdm_prev_d;
            dcnt_q     <= dcnt_d;
            pend_q     <= pend_d;
            left_pcm_q <= left_pcm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            for (int ch = 0; ch < 2; ch++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ_q[ch][k] <= integ_d[ch][k];
                    comb_q[ch][k]  <= comb_d[ch][k];
                end
            end
        end
    end

    // Frame storage, contents need no reset
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= push_data_c;
    end
endmodule

// File: tb/tb_tqvp_jnms_pdm_multi.sv
// Self-checking bench for tqvp_jnms_pdm_multi: register access, PDM clock shape,
// mono/stereo decimation, FIFO overflow/underflow, threshold interrupt, async reset.
module tb_tqvp_jnms_pdm_multi;
    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_PERIOD = 6'h04;
    localparam logic [5:0] A_DATA   = 6'h08;
    localparam logic [5:0] A_STATUS = 6'h0C;
    localparam int FRAME_WAIT = 6 * 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;
    logic        din_val;
    logic        follow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    assign ui_in = {7'b0, follow ? uo_out[0] : din_val};

    always #5 clk = ~clk;

    tqvp_jnms_pdm_multi dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        address      = a;
        data_in      = d;
        data_write_n = sz;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        address     = a;
        data_read_n = 2'b10;
        #1 d = data_out;
        @(negedge clk);
        data_read_n = 2'b11;
    endtask

    task automatic wait_level(input int n);
        logic [31:0] st;
        bit ok;
        ok = 1'b0;
        st = '0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            bus_read(A_STATUS, st);
            if (32'(st[4:0]) >= n) ok = 1'b1;
        end
        if (!ok) check("wait_level", 32'(st[4:0]), 32'(n));
    endtask

    task automatic wait_over();
        logic [31:0] st;
        bit ok;
        ok = 1'b0;
        st = '0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            bus_read(A_STATUS, st);
            if (st[10]) ok = 1'b1;
        end
        if (!ok) check("wait_over", 32'(st[10]), 32'd1);
    endtask

    // Pop n frames from the DUT and compare against the scoreboard
    task automatic drain(input int n, input string tag);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            bus_read(A_DATA, d);
            if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
            else check(tag, d, exp_q.pop_front());
        end
    endtask

    task automatic expect_frames(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Capture 16 cycles of the PDM clock starting at a rising edge
    task automatic capture16(input string tag, input logic [15:0] exp);
        logic [15:0] v;
        bit ok;
        v  = '0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (uo_out[0] == 1'b0) ok = 1'b1;
        end
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                if (uo_out[0] == 1'b1) ok = 1'b1;
            end
        end
        if (!ok) begin
            check({tag, "_sync"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_all_bits"}, 32'(uo_out), 32'hFF);
            v[0] = uo_out[0];
            for (int i = 1; i < 16; i++) begin
                @(negedge clk);
                v[i] = uo_out[0];
            end
            check(tag, 32'(v), 32'(exp));
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  acc;
        bit ok;

        rst_n        = 1'b0;
        address      = '0;
        data_in      = '0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        din_val      = 1'b0;
        follow       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_uo_out", 32'(uo_out), 32'h0);
        check("rst_irq", 32'(user_interrupt), 32'h0);
        check("data_ready", 32'(data_ready), 32'h1);
        bus_read(A_CTRL, d);   check("rst_ctrl", d, 32'h0);
        bus_read(A_PERIOD, d); check("rst_period", d, 32'h0);
        bus_read(A_STATUS, d); check("rst_status", d, 32'h100);

        // Byte write reaches EN only, THRESH untouched
        bus_write(A_CTRL, 32'h0000_0F01, 2'b00);
        bus_read(A_CTRL, d); check("byte_ctrl", d, 32'h1);

        // Clock generator
        bus_write(A_PERIOD, 32'd8, 2'b10);
        capture16("clk_p8", 16'h0F0F);
        bus_write(A_PERIOD, 32'd1, 2'b10);
        capture16("clk_p1", 16'h5555);
        bus_write(A_CTRL, 32'h0, 2'b10);
        acc = '0;
        repeat (6) begin
            @(negedge clk);
            acc = acc | uo_out;
        end
        check("clk_en0", 32'(acc), 32'h0);

        // Mono, DIN high then low
        bus_write(A_PERIOD, 32'd2, 2'b10);
        din_val = 1'b1;
        bus_write(A_CTRL, 32'h1, 2'b10);
        repeat (FRAME_WAIT) @(negedge clk);
        bus_write(A_CTRL, 32'h5, 2'b10);
        expect_frames(3, 32'h0000_7FFF);
        wait_level(3);
        drain(3, "mono_one");
        din_val = 1'b0;
        repeat (FRAME_WAIT) @(negedge clk);
        bus_write(A_CTRL, 32'h5, 2'b10);
        expect_frames(3, 32'h0000_8000);
        wait_level(3);
        drain(3, "mono_zero");

        // Stereo, DIN follows the PDM clock
        bus_write(A_CTRL, 32'h0, 2'b10);
        follow = 1'b1;
        bus_write(A_CTRL, 32'h3, 2'b10);
        bus_read(A_CTRL, d); check("ctrl_stereo", d, 32'h3);
        repeat (FRAME_WAIT) @(negedge clk);
        bus_write(A_CTRL, 32'h7, 2'b10);
        expect_frames(3, 32'h7FFF_8000);
        wait_level(3);
        drain(3, "stereo");

        // Overflow
        bus_write(A_CTRL, 32'h7, 2'b10);
        bus_write(A_STATUS, 32'hC00, 2'b10);
        expect_frames(8, 32'h7FFF_8000);
        wait_over();
        bus_write(A_CTRL, 32'h2, 2'b10);
        bus_read(A_STATUS, d); check("over_status", d, 32'h608);
        check("over_irq", 32'(user_interrupt), 32'h1);
        drain(1, "over_first");
        check("over_irq_after_pop", 32'(user_interrupt), 32'h1);
        bus_write(A_STATUS, 32'h400, 2'b10);
        bus_read(A_STATUS, d); check("over_cleared", d, 32'h007);
        check("over_irq_cleared", 32'(user_interrupt), 32'h0);

        // Threshold interrupt and underflow
        bus_write(A_CTRL, 32'h402, 2'b10);
        bus_read(A_CTRL, d); check("ctrl_thresh", d, 32'h402);
        check("thr_irq_l7", 32'(user_interrupt), 32'h1);
        drain(3, "thr_pop");
        check("thr_irq_l4", 32'(user_interrupt), 32'h1);
        drain(1, "thr_pop");
        check("thr_irq_l3", 32'(user_interrupt), 32'h0);
        drain(3, "thr_pop");
        bus_read(A_DATA, d); check("under_data", d, 32'h0);
        bus_read(A_STATUS, d); check("under_status", d, 32'h900);
        check("under_irq", 32'(user_interrupt), 32'h0);
        bus_write(A_STATUS, 32'h800, 2'b10);
        bus_read(A_STATUS, d); check("under_cleared", d, 32'h100);
        bus_write(A_CTRL, 32'h403, 2'b10);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (user_interrupt) ok = 1'b1;
        end
        check("thr_irq_rise", 32'(ok), 32'h1);
        bus_write(A_CTRL, 32'h402, 2'b10);
        bus_read(A_STATUS, d); check("thr_level", 32'(d[4:0]), 32'd4);
        bus_read(A_DATA, d);
        check("thr_irq_fall", 32'(user_interrupt), 32'h0);
        bus_write(A_CTRL, 32'h406, 2'b10);
        bus_read(A_STATUS, d); check("flush_status", d, 32'h100);

        // Async reset mid-operation, then PERIOD=0 acts as 2
        follow  = 1'b0;
        din_val = 1'b1;
        bus_write(A_PERIOD, 32'd0, 2'b10);
        bus_write(A_CTRL, 32'h401, 2'b10);
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_uo", 32'(uo_out), 32'h0);
        check("rst_mid_irq", 32'(user_interrupt), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_CTRL, d);   check("rst2_ctrl", d, 32'h0);
        bus_read(A_PERIOD, d); check("rst2_period", d, 32'h0);
        bus_read(A_STATUS, d); check("rst2_status", d, 32'h100);
        bus_write(A_CTRL, 32'h1, 2'b10);
        repeat (FRAME_WAIT) @(negedge clk);
        bus_write(A_CTRL, 32'h5, 2'b10);
        expect_frames(3, 32'h0000_7FFF);
        wait_level(3);
        drain(3, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
